timer_sched: RTL and testbench
==============================

# timer_sched

Round-robin scheduler sharing one delay timer (start/done handshake, N-bit internal delay counter, done pulse after start drops or the counter wraps) among M requesters. It picks one requester and drives the timer's start from that requester's req. It returns the timer's done pulse to the owner and aborts hung or abandoned sessions. It sits between requester blocks and a single timer instance.

## Interface
- M, 4: number of requesters (2..8)
- N, 3: timer counter width; the timer self-terminates after at most 2^N cycles of start
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; clears all state immediately
- req  in  M  level requests; requester holds req high for as long as it wants the timer running
- grant  out  M  one-hot owner, all-zero when idle
- timer_start  out  1  to timer start input
- timer_done  in  1  timer done pulse
- done_out  out  M  one-cycle pulse to the owner on normal completion
- err_out  out  1  one-cycle pulse on abort (watchdog or abandoned grant)
- busy  out  1  high while not IDLE

## Operation
- States: IDLE, RUN, FINISH (2-bit enum).
- IDLE, if any req bit is set:
  - select the first set bit searching from (last+1) mod M upward with wrap; `last` resets to M-1, so index 0 wins first
  - register owner and last=owner
  - -> RUN; clear watchdog and `started`
- RUN:
  - timer_start = req[owner] (combinational gate, RUN only)
  - `started` sets on the first cycle timer_start is 1
  - watchdog counts cycles in RUN (width N+2)
  - exit priority, evaluated every cycle:
    1. timer_done=1 -> FINISH, normal
    2. req[owner]=0 and started=0 -> FINISH, abort (abandoned)
    3. watchdog = 2^N+3 -> FINISH, abort (hung timer)
- FINISH (exactly one cycle):
  - timer_start=0; grant still shows owner
  - normal completion: done_out[owner]=1, err_out=0
  - abort: err_out=1, done_out=0
  - -> IDLE
- IDLE: grant=0, timer_start=0; timer_done ignored.
- One session at a time. Other requesters wait with req high and are never dropped; the round-robin rotation bounds the wait to M-1 sessions.
- A requester dropping req after `started` is a normal release: the timer produces done, and the scheduler follows exit rule 1.

## Timing
- Reset values: grant=0, timer_start=0, done_out=0, err_out=0, busy=0, state=IDLE, last=M-1.
- req sampled at edge k in IDLE -> grant and busy high from k+1; timer_start high from k+1 if req[owner] is still high.
- The timer reports done the cycle after start falls, or 2^N cycles after start rose. timer_done at edge j -> done_out pulse in cycle j+1 -> IDLE at j+2; the earliest next grant is j+3.
- FINISH holds timer_start low for one cycle before IDLE, so the timer returns to its idle state before any re-grant.
- timer_done in the same cycle as rule 2 or 3 conditions: rule 1 wins (normal completion).
- Reset asserted mid-RUN: all outputs drop asynchronously. No done_out or err_out is emitted, and `last` is restored to M-1.
- Watchdog limit 2^N+3 covers the maximum timer run plus handshake slack; it never fires with a working timer.

## Structure
- `timer_sched_pkg`:
  - state enum typedef
  - function `wdog_limit(N)` returning 2^N+3
- Sub-module `rr_pick #(M)`: combinational; inputs req and last, outputs a valid flag and the index. It is the only natural split.
- Expected size about 150-220 lines including rr_pick.

## Test plan
- Single requester, M=4, N=3: req=0001 for 3 cycles then low, bench timer model. Required: grant=0001 one cycle after req, timer_start for 3 cycles, done_out=0001 one pulse, err_out never set.
- req=1111 held continuously, each requester drops its own req 2 cycles after its grant. Required: grant order 0,1,2,3,0, one done_out pulse per requester per session.
- Owner holds req 20 cycles, N=3. Required: timer self-terminates at 8 cycles, done_out pulses, grant moves to the next requester even though the owner's req is still high.
- req[2] pulses for one cycle only, so req[owner]=0 in the first RUN cycle. Required: err_out pulse, no done_out, timer_start never high.
- Bench timer model never returns done. Required: err_out exactly 2^N+3 = 11 cycles after entry to RUN, then IDLE.
- Reset asserted in the 2nd RUN cycle. Required: grant, timer_start and busy drop in the same cycle with no done or err pulse; after release, req=1111 grants index 0 first.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the round-robin timer scheduler.
// The watchdog limit leaves three cycles of handshake slack beyond the longest timer run.
package timer_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   function automatic int unsigned wdog_limit(input int unsigned n);
      return (32'd1 << n) + 32'd3;
   endfunction

endpackage

// File: rtl/timer_sched_rr_pick.sv
// Combinational round-robin selector: the first set request bit strictly after
// 'last', wrapping around, so the previous owner is considered last.
module rr_pick #(
   parameter int M  = 4,
   parameter int IW = $clog2(M)
) (
   input  logic [M-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Walk candidates from farthest to nearest so the nearest hit is written last.
   always_comb begin
      int cand;
      logic [IW-1:0] candIdx;
      valid   = 1'b0;
      idx     = '0;
      cand    = 0;
      candIdx = '0;
      for (int d = M; d >= 1; d--) begin
         cand    = (int'(last) + d) % M;
         candIdx = IW'(cand);
         if (req[candIdx]) begin
            valid = 1'b1;
            idx   = candIdx;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Shares one delay timer among M requesters: round-robin grant, start gating,
// done routing back to the owner, and abort of abandoned or hung sessions.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int M = 4,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [M-1:0] req,
   output logic [M-1:0] grant,
   output logic         timer_start,
   input  logic         timer_done,
   output logic [M-1:0] done_out,
   output logic         err_out,
   output logic         busy
);

   localparam int IW = $clog2(M);
   localparam int WW = N + 2;
   localparam logic [WW-1:0] WDOG_LAST = WW'(wdog_limit(N) - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          started_q, started_d;
   logic          abort_q, abort_d;

   logic          pickValid;
   logic [IW-1:0] pickIdx;
   logic          ownerReq;
   logic [M-1:0]  ownerOneHot;

   rr_pick #(.M(M), .IW(IW)) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pickValid),
      .idx   (pickIdx)
   );

   assign ownerReq    = req[owner_q];
   assign ownerOneHot = M'(1) << owner_q;

   // State register; reset puts the rotation pointer on M-1 so index 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         last_q    <= IW'(M - 1);
         wdog_q    <= '0;
         started_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         wdog_q    <= wdog_d;
         started_q <= started_d;
         abort_q   <= abort_d;
      end
   end

   // Next state and outputs. In RUN a timer done beats both abort causes.
   // wdog_q counts completed RUN cycles, so WDOG_LAST marks the limit-th RUN cycle.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wdog_d      = wdog_q;
      started_d   = started_q;
      abort_d     = abort_q;
      grant       = '0;
      timer_start = 1'b0;
      done_out    = '0;
      err_out     = 1'b0;
      busy        = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (pickValid) begin
               owner_d   = pickIdx;
               last_d    = pickIdx;
               wdog_d    = '0;
               started_d = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            grant       = ownerOneHot;
            timer_start = ownerReq;
            started_d   = started_q | ownerReq;
            wdog_d      = wdog_q + 1'b1;
            if (timer_done) begin
               abort_d = 1'b0;
               state_d = FINISH;
            end else if (!ownerReq && !started_q) begin
               abort_d = 1'b1;
               state_d = FINISH;
            end else if (wdog_q == WDOG_LAST) begin
               abort_d = 1'b1;
               state_d = FINISH;
            end
         end
         FINISH: begin
            grant = ownerOneHot;
            if (abort_q) begin
               err_out = 1'b1;
            end else begin
               done_out = ownerOneHot;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: a behavioural timer, a round-robin
// ownership model and one task per scenario, including randomized sessions.
module tb_timer_sched;

   localparam int M    = 4;
   localparam int N    = 3;
   localparam int TMAX = 1 << N;
   localparam int WDOG = (1 << N) + 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [M-1:0] req = '0;
   logic [M-1:0] grant;
   logic         timer_start;
   logic         timer_done = 1'b0;
   logic [M-1:0] done_out;
   logic         err_out;
   logic         busy;

   timer_sched #(.M(M), .N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .timer_start (timer_start),
      .timer_done  (timer_done),
      .done_out    (done_out),
      .err_out     (err_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int lastM = M - 1;
   bit hang = 1'b0;

   // Behavioural timer: done the cycle after start falls, or after TMAX high cycles.
   // After a self-terminated run it waits for start to drop before re-arming.
   logic tmrRun = 1'b0;
   logic tmrWaitLow = 1'b0;
   int   tCnt = 0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_done <= 1'b0;
         tmrRun     <= 1'b0;
         tmrWaitLow <= 1'b0;
         tCnt       <= 0;
      end else begin
         timer_done <= 1'b0;
         if (tmrWaitLow) begin
            if (!timer_start) tmrWaitLow <= 1'b0;
         end else if (!tmrRun) begin
            if (timer_start) begin
               tmrRun <= 1'b1;
               tCnt   <= 1;
            end
         end else if (!timer_start) begin
            tmrRun <= 1'b0;
            if (!hang) timer_done <= 1'b1;
         end else if (tCnt == TMAX - 1) begin
            tmrRun     <= 1'b0;
            tmrWaitLow <= 1'b1;
            if (!hang) timer_done <= 1'b1;
         end else begin
            tCnt <= tCnt + 1;
         end
      end
   end

   // Free-running event totals sampled mid-cycle; tasks work with differences.
   int stTot = 0;
   int doneTot = 0;
   int errTot = 0;
   logic [M-1:0] lastDone = '0;
   always @(negedge clk) begin
      if (timer_start) stTot++;
      if (done_out != '0) begin
         doneTot++;
         lastDone = done_out;
      end
      if (err_out) errTot++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rrModel(input logic [M-1:0] mask, input int last);
      for (int d = 1; d <= M; d++) begin
         if (mask[(last + d) % M]) return (last + d) % M;
      end
      return -1;
   endfunction

   function automatic logic [M-1:0] oneHot(input int i);
      logic [M-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // Expected timer_start cycles when the owner holds for 'hold' cycles: the timer
   // ends the run after TMAX cycles and the scheduler leaves RUN one cycle later.
   function automatic int expStart(input int hold);
      return (hold <= TMAX) ? hold : TMAX + 1;
   endfunction

   int sOwn, sStart, sDone, sErr, sErrAt, sEnd;
   logic [M-1:0] sGrant, sLastDone;
   bit sBusy, sTimeout;

   // Runs one session from IDLE: raises newBits, owner holds req for 'hold'
   // timer_start cycles (0 = one-cycle pulse only), then waits for IDLE.
   task automatic driveSession(input logic [M-1:0] newBits, input int hold);
      int b0s, b0d, b0e;
      req  = req | newBits;
      sOwn = rrModel(req, lastM);
      if (sOwn >= 0) lastM = sOwn;
      b0s = stTot;
      b0d = doneTot;
      b0e = errTot;
      tick;
      sGrant = grant;
      sBusy  = busy;
      if (hold == 0 && sOwn >= 0) req[sOwn] = 1'b0;
      sTimeout = 1'b1;
      sErrAt   = -1;
      sEnd     = -1;
      for (int c = 0; c < 60; c++) begin
         tick;
         if (err_out && sErrAt < 0) sErrAt = c + 1;
         if (hold > 0 && sOwn >= 0 && (stTot - b0s) >= hold) req[sOwn] = 1'b0;
         if (!busy) begin
            sTimeout = 1'b0;
            sEnd     = c + 1;
            break;
         end
      end
      sStart    = stTot - b0s;
      sDone     = doneTot - b0d;
      sErr      = errTot - b0e;
      sLastDone = lastDone;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      checks++; if (grant !== '0) begin errors++; $display("[TB] FAIL reset_grant got=%b exp=0", grant); end
      checks++; if (timer_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got=%b exp=0", timer_start); end
      checks++; if (done_out !== '0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done_out); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b0;
      lastM = M - 1;
      tick;
   endtask

   task automatic test_back_to_back;
      int order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         driveSession('1, 2);
         checks++; if (sGrant !== oneHot(order[i])) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", i, sGrant, oneHot(order[i])); end
         checks++; if (sDone != 1 || sLastDone !== oneHot(order[i])) begin errors++; $display("[TB] FAIL rr_done%0d got=%0d/%b exp=1/%b", i, sDone, sLastDone, oneHot(order[i])); end
         checks++; if (sErr != 0 || sTimeout) begin errors++; $display("[TB] FAIL rr_err%0d got=%0d timeout=%0d exp=0", i, sErr, sTimeout); end
      end
      req = '0;
   endtask

   task automatic test_single;
      driveSession(4'b0001, 3);
      checks++; if (sGrant !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0001", sGrant); end
      checks++; if (sBusy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=1", sBusy); end
      checks++; if (sStart != 3) begin errors++; $display("[TB] FAIL single_start got=%0d exp=3", sStart); end
      checks++; if (sDone != 1 || sLastDone !== 4'b0001) begin errors++; $display("[TB] FAIL single_done got=%0d/%b exp=1/0001", sDone, sLastDone); end
      checks++; if (sErr != 0 || sTimeout) begin errors++; $display("[TB] FAIL single_err got=%0d timeout=%0d exp=0", sErr, sTimeout); end
      req = '0;
   endtask

   task automatic test_abandon;
      driveSession(4'b0100, 0);
      checks++; if (sGrant !== 4'b0100) begin errors++; $display("[TB] FAIL abandon_grant got=%b exp=0100", sGrant); end
      checks++; if (sErr != 1) begin errors++; $display("[TB] FAIL abandon_err got=%0d exp=1", sErr); end
      checks++; if (sDone != 0) begin errors++; $display("[TB] FAIL abandon_done got=%0d exp=0", sDone); end
      checks++; if (sStart != 0 || sTimeout) begin errors++; $display("[TB] FAIL abandon_start got=%0d timeout=%0d exp=0", sStart, sTimeout); end
      req = '0;
   endtask

   task automatic test_wrap;
      int firstOwn;
      driveSession(4'b1010, 20);
      firstOwn = sOwn;
      checks++; if (sGrant !== oneHot(firstOwn)) begin errors++; $display("[TB] FAIL wrap_grant got=%b exp=%b", sGrant, oneHot(firstOwn)); end
      checks++; if (sStart != expStart(20)) begin errors++; $display("[TB] FAIL wrap_start got=%0d exp=%0d", sStart, expStart(20)); end
      checks++; if (sDone != 1 || sLastDone !== oneHot(firstOwn)) begin errors++; $display("[TB] FAIL wrap_done got=%0d/%b exp=1/%b", sDone, sLastDone, oneHot(firstOwn)); end
      checks++; if (sErr != 0 || sTimeout) begin errors++; $display("[TB] FAIL wrap_err got=%0d timeout=%0d exp=0", sErr, sTimeout); end
      driveSession('0, 2);
      checks++; if (sGrant !== oneHot(sOwn) || sOwn == firstOwn) begin errors++; $display("[TB] FAIL wrap_next got=%b exp=%b", sGrant, oneHot(sOwn)); end
      req = '0;
   endtask

   task automatic test_hang;
      hang = 1'b1;
      driveSession(4'b0001, 1000);
      checks++; if (sErrAt != WDOG) begin errors++; $display("[TB] FAIL hang_err_time got=%0d exp=%0d", sErrAt, WDOG); end
      checks++; if (sErr != 1 || sDone != 0) begin errors++; $display("[TB] FAIL hang_pulses got=err%0d/done%0d exp=err1/done0", sErr, sDone); end
      checks++; if (sEnd != WDOG + 1 || sTimeout) begin errors++; $display("[TB] FAIL hang_idle got=%0d exp=%0d", sEnd, WDOG + 1); end
      req  = '0;
      hang = 1'b0;
      tick;
   endtask

   task automatic test_random;
      int hold;
      logic [M-1:0] nb;
      for (int i = 0; i < 12; i++) begin
         hold = $urandom_range(0, 11);
         nb   = M'($urandom_range(1, (1 << M) - 1));
         driveSession(nb, hold);
         checks++; if (sGrant !== oneHot(sOwn)) begin errors++; $display("[TB] FAIL rand%0d_grant got=%b exp=%b", i, sGrant, oneHot(sOwn)); end
         checks++; if (sStart != expStart(hold)) begin errors++; $display("[TB] FAIL rand%0d_start got=%0d exp=%0d", i, sStart, expStart(hold)); end
         if (hold == 0) begin
            checks++; if (sErr != 1 || sDone != 0 || sTimeout) begin errors++; $display("[TB] FAIL rand%0d_abort got=err%0d/done%0d exp=err1/done0", i, sErr, sDone); end
         end else begin
            checks++; if (sDone != 1 || sLastDone !== oneHot(sOwn) || sErr != 0 || sTimeout) begin errors++; $display("[TB] FAIL rand%0d_done got=%0d/%b err%0d exp=1/%b err0", i, sDone, sLastDone, sErr, oneHot(sOwn)); end
         end
      end
      req = '0;
      tick;
   endtask

   task automatic test_reset_midrun;
      int d0, e0;
      req = 4'b0100;
      tick;
      tick;
      d0 = doneTot;
      e0 = errTot;
      reset = 1'b1;
      #1;
      checks++; if (grant !== '0 || timer_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_drop got=g%b s%b b%b exp=all0", grant, timer_start, busy); end
      req = '0;
      tick;
      tick;
      reset = 1'b0;
      lastM = M - 1;
      checks++; if (doneTot != d0 || errTot != e0) begin errors++; $display("[TB] FAIL midrun_pulses got=done%0d/err%0d exp=0/0", doneTot - d0, errTot - e0); end
      req = 4'b1111;
      tick;
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL midrun_regrant got=%b exp=0001", grant); end
      req = '0;
      repeat (4) tick;
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_single;
      test_abandon;
      test_wrap;
      test_hang;
      test_random;
      test_reset_midrun;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
